// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants: S-memory geometry, byte type and the PRGA state encoding.
package rc4_pkg;

  localparam int unsigned S_SIZE = 256;
  localparam int unsigned S_AW   = 8;

  typedef logic [7:0] byte_t;

  // One-hot PRGA sequencer states; any other encoding is treated as illegal.
  typedef enum logic [14:0] {
    StIdle     = 15'h0001,
    StInit     = 15'h0002,
    StIncI     = 15'h0004,
    StReadSi   = 15'h0008,
    StWaitSi   = 15'h0010,
    StCalcJ    = 15'h0020,
    StReadSj   = 15'h0040,
    StWaitSj   = 15'h0080,
    StWriteSi  = 15'h0100,
    StWriteSj  = 15'h0200,
    StReadF    = 15'h0400,
    StWaitF    = 15'h0800,
    StWriteOut = 15'h1000,
    StNextK    = 15'h2000,
    StFinish   = 15'h4000
  } prga_state_e;

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator: walks the permuted S memory with the PRGA, swaps entries in place,
// and writes ciphertext XOR keystream for every message byte to the decrypted-message RAM.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned K_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [7:0]      s_q_i,
  output logic [S_AW-1:0] s_addr_o,
  output logic [7:0]      s_data_o,
  output logic            s_wren_o,
  input  logic [7:0]      rom_q_i,
  output logic [K_W-1:0]  rom_addr_o,
  output logic [K_W-1:0]  ram_addr_o,
  output logic [7:0]      ram_data_o,
  output logic            ram_wren_o,
  output logic            done_o
);

  localparam logic [K_W-1:0] LastK = K_W'(MSG_LEN - 1);

  prga_state_e    state_q, state_d;
  byte_t          i_q, i_d;
  byte_t          j_q, j_d;
  byte_t          si_q, si_d;
  byte_t          sj_q, sj_d;
  byte_t          f_q, f_d;
  byte_t          enc_q, enc_d;
  logic [K_W-1:0] k_q, k_d;

  // Message index drives both the ciphertext fetch and the plaintext store.
  assign rom_addr_o = k_q;
  assign ram_addr_o = k_q;

  // Next-state, datapath updates and memory strobes, decoded from the current state.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    enc_d      = enc_q;
    k_d        = k_q;
    s_addr_o   = '0;
    s_data_o   = '0;
    s_wren_o   = 1'b0;
    ram_data_o = '0;
    ram_wren_o = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StInit;
      end
      StInit: begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = StIncI;
      end
      StIncI: begin
        i_d     = i_q + 8'd1;
        state_d = StReadSi;
      end
      StReadSi: begin
        s_addr_o = i_q;
        state_d  = StWaitSi;
      end
      StWaitSi: begin
        s_addr_o = i_q;
        si_d     = s_q_i;
        state_d  = StCalcJ;
      end
      StCalcJ: begin
        j_d     = j_q + si_q;
        state_d = StReadSj;
      end
      StReadSj: begin
        s_addr_o = j_q;
        state_d  = StWaitSj;
      end
      StWaitSj: begin
        s_addr_o = j_q;
        sj_d     = s_q_i;
        state_d  = StWriteSi;
      end
      // Swap is two single-port writes; when i == j both store the original value.
      StWriteSi: begin
        s_addr_o = i_q;
        s_data_o = sj_q;
        s_wren_o = 1'b1;
        state_d  = StWriteSj;
      end
      StWriteSj: begin
        s_addr_o = j_q;
        s_data_o = si_q;
        s_wren_o = 1'b1;
        state_d  = StReadF;
      end
      // si + sj equals S[i] + S[j] after the swap, so the pre-swap registers suffice.
      StReadF: begin
        s_addr_o = si_q + sj_q;
        state_d  = StWaitF;
      end
      StWaitF: begin
        s_addr_o = si_q + sj_q;
        f_d      = s_q_i;
        enc_d    = rom_q_i;
        state_d  = StWriteOut;
      end
      StWriteOut: begin
        ram_data_o = f_q ^ enc_q;
        ram_wren_o = 1'b1;
        state_d    = StNextK;
      end
      StNextK: begin
        if (k_q == LastK) begin
          state_d = StFinish;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = StIncI;
        end
      end
      StFinish: begin
        done_o = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Dropping start aborts from any state; memory writes already made stay in place.
    if (!start_i) begin
      state_d = StIdle;
      i_d     = '0;
      j_d     = '0;
      si_d    = '0;
      sj_d    = '0;
      f_d     = '0;
      enc_d   = '0;
      k_d     = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      enc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      enc_q   <= enc_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: three instances (2, 32 and 300 byte messages) on shared clock and
// reset, each with its own S memory, ciphertext ROM and plaintext RAM, checked against a plain
// RC4 reference model.
module tb_rc4_prga_decrypt;
  import rc4_pkg::*;

  localparam int unsigned LenA = 2;
  localparam int unsigned LenB = 32;
  localparam int unsigned LenC = 300;
  localparam int unsigned KwA  = $clog2(LenA);
  localparam int unsigned KwB  = $clog2(LenB);
  localparam int unsigned KwC  = $clog2(LenC);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Instance A
  logic           start_a, s_wren_a, ram_wren_a, done_a;
  logic [7:0]     s_q_a, s_addr_a, s_data_a, rom_q_a, ram_data_a;
  logic [KwA-1:0] rom_addr_a, ram_addr_a;
  logic [7:0]     s_a [256];
  logic [7:0]     rom_a [LenA];
  logic [7:0]     ram_a [LenA];
  logic [15:0]    wr_a [$];
  // Instance B
  logic           start_b, s_wren_b, ram_wren_b, done_b;
  logic [7:0]     s_q_b, s_addr_b, s_data_b, rom_q_b, ram_data_b;
  logic [KwB-1:0] rom_addr_b, ram_addr_b;
  logic [7:0]     s_b [256];
  logic [7:0]     rom_b [LenB];
  logic [7:0]     ram_b [LenB];
  logic [7:0]     pt_b [LenB];
  logic [15:0]    wr_b [$];
  // Instance C
  logic           start_c, s_wren_c, ram_wren_c, done_c;
  logic [7:0]     s_q_c, s_addr_c, s_data_c, rom_q_c, ram_data_c;
  logic [KwC-1:0] rom_addr_c, ram_addr_c;
  logic [7:0]     s_c [256];
  logic [7:0]     rom_c [LenC];
  logic [7:0]     ram_c [LenC];
  logic [7:0]     pt_c [LenC];
  logic [15:0]    wr_c [$];

  // Reference model state
  logic [7:0]  m_s [256];
  logic [7:0]  m_ks [$];
  logic [15:0] m_wr [$];

  rc4_prga_decrypt #(.MSG_LEN(LenA)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .s_q_i(s_q_a), .s_addr_o(s_addr_a), .s_data_o(s_data_a), .s_wren_o(s_wren_a),
    .rom_q_i(rom_q_a), .rom_addr_o(rom_addr_a), .ram_addr_o(ram_addr_a),
    .ram_data_o(ram_data_a), .ram_wren_o(ram_wren_a), .done_o(done_a)
  );
  rc4_prga_decrypt #(.MSG_LEN(LenB)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .s_q_i(s_q_b), .s_addr_o(s_addr_b), .s_data_o(s_data_b), .s_wren_o(s_wren_b),
    .rom_q_i(rom_q_b), .rom_addr_o(rom_addr_b), .ram_addr_o(ram_addr_b),
    .ram_data_o(ram_data_b), .ram_wren_o(ram_wren_b), .done_o(done_b)
  );
  rc4_prga_decrypt #(.MSG_LEN(LenC)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c),
    .s_q_i(s_q_c), .s_addr_o(s_addr_c), .s_data_o(s_data_c), .s_wren_o(s_wren_c),
    .rom_q_i(rom_q_c), .rom_addr_o(rom_addr_c), .ram_addr_o(ram_addr_c),
    .ram_data_o(ram_data_c), .ram_wren_o(ram_wren_c), .done_o(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories, 1-cycle read latency, old data on read-during-write; S writes logged.
  always @(posedge clk) begin
    s_q_a   <= s_a[s_addr_a];
    rom_q_a <= rom_a[rom_addr_a];
    if (s_wren_a) begin
      s_a[s_addr_a] = s_data_a;
      wr_a.push_back({s_addr_a, s_data_a});
    end
    if (ram_wren_a) ram_a[ram_addr_a] = ram_data_a;
  end
  always @(posedge clk) begin
    s_q_b   <= s_b[s_addr_b];
    rom_q_b <= rom_b[rom_addr_b];
    if (s_wren_b) begin
      s_b[s_addr_b] = s_data_b;
      wr_b.push_back({s_addr_b, s_data_b});
    end
    if (ram_wren_b) ram_b[ram_addr_b] = ram_data_b;
  end
  always @(posedge clk) begin
    s_q_c   <= s_c[s_addr_c];
    rom_q_c <= rom_c[rom_addr_c];
    if (s_wren_c) begin
      s_c[s_addr_c] = s_data_c;
      wr_c.push_back({s_addr_c, s_data_c});
    end
    if (ram_wren_c) ram_c[ram_addr_c] = ram_data_c;
  end

  // Key schedule with the 3-byte all-zero key, leaving the permutation in m_s.
  task automatic ksa_zero_key();
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key = '{8'h00, 8'h00, 8'h00};
    j = 0;
    for (int x = 0; x < 256; x++) m_s[x] = x[7:0];
    for (int x = 0; x < 256; x++) begin
      j = (j + m_s[x] + key[x % 3]) % 256;
      t = m_s[x]; m_s[x] = m_s[j]; m_s[j] = t;
    end
  endtask

  // Textbook RC4 PRGA on m_s: keystream bytes and the (addr,data) S writes the swap implies.
  task automatic prga_model(input int n);
    int i, j;
    logic [7:0] t;
    i = 0;
    j = 0;
    m_ks.delete();
    m_wr.delete();
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      m_wr.push_back({i[7:0], m_s[i]});
      m_wr.push_back({j[7:0], m_s[j]});
      m_ks.push_back(m_s[(m_s[i] + m_s[j]) % 256]);
    end
  endtask

  // Waits for done of instance sel; cyc is the cycle number (start sampled at edge 0), -1 on timeout.
  task automatic run_to_done(input int sel, input int limit, output int cyc);
    logic d;
    cyc = -1;
    for (int e = 0; e < limit; e++) begin
      @(posedge clk);
      #1;
      case (sel)
        0:       d = done_a;
        1:       d = done_b;
        default: d = done_c;
      endcase
      if (d === 1'b1) begin
        cyc = e + 1;
        break;
      end
    end
  endtask

  task automatic preset_a();
    for (int x = 0; x < 256; x++) s_a[x] = x[7:0];
    rom_a[0] = 8'hA0;
    rom_a[1] = 8'h55;
    ram_a[0] = 8'h00;
    ram_a[1] = 8'h00;
    wr_a.delete();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ((|{s_addr_a, s_data_a, s_wren_a, ram_data_a, ram_wren_a, done_a, rom_addr_a,
           ram_addr_a}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_a: some output nonzero, want all 0");
    end
    checks++;
    if ((|{s_addr_b, s_wren_b, ram_wren_b, done_b, ram_addr_b, s_addr_c, s_wren_c, ram_wren_c,
           done_c, ram_addr_c}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_bc: some output nonzero, want all 0");
    end
    checks++;
    if (u_a.state_q !== StIdle) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", u_a.state_q, StIdle);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done_a, s_wren_a, ram_wren_a} !== 3'b000) begin
      errors++;
      $display("FAIL idle_without_start: got %b want 000", {done_a, s_wren_a, ram_wren_a});
    end
  endtask

  task automatic test_identity();
    int cyc;
    preset_a();
    @(posedge clk);
    #1;
    start_a = 1'b1;
    run_to_done(0, 100, cyc);
    checks++;
    if (cyc != 26) begin
      errors++;
      $display("FAIL ident_done_cycle: got %0d want 26", cyc);
    end
    checks++;
    if (ram_a[0] !== 8'hA2) begin
      errors++;
      $display("FAIL ident_ram0: got %h want a2", ram_a[0]);
    end
    checks++;
    if (ram_a[1] !== 8'h50) begin
      errors++;
      $display("FAIL ident_ram1: got %h want 50", ram_a[1]);
    end
    checks++;
    if ({s_a[2], s_a[3]} !== 16'h0302) begin
      errors++;
      $display("FAIL ident_swap: got S2=%h S3=%h want 03 02", s_a[2], s_a[3]);
    end
    start_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Relies on the write log left by test_identity: byte 0 has i == j == 1.
  task automatic test_i_eq_j();
    checks++;
    if (wr_a.size() != 4) begin
      errors++;
      $display("FAIL ieqj_write_count: got %0d want 4", wr_a.size());
    end else begin
      checks++;
      if (wr_a[0] !== 16'h0101 || wr_a[1] !== 16'h0101) begin
        errors++;
        $display("FAIL ieqj_writes: got %h %h want 0101 0101", wr_a[0], wr_a[1]);
      end
    end
    checks++;
    if (s_a[1] !== 8'h01) begin
      errors++;
      $display("FAIL ieqj_s1: got %h want 01", s_a[1]);
    end
  endtask

  task automatic test_known_answer();
    int cyc;
    int bad;
    ksa_zero_key();
    for (int x = 0; x < 256; x++) s_b[x] = m_s[x];
    prga_model(LenB);
    for (int k = 0; k < LenB; k++) begin
      pt_b[k]  = 8'($urandom());
      rom_b[k] = pt_b[k] ^ m_ks[k];
      ram_b[k] = 8'h00;
    end
    wr_b.delete();
    @(posedge clk);
    #1;
    start_b = 1'b1;
    run_to_done(1, 1000, cyc);
    checks++;
    if (cyc != 2 + 12 * LenB) begin
      errors++;
      $display("FAIL kat_done_cycle: got %0d want %0d", cyc, 2 + 12 * LenB);
    end
    for (int k = 0; k < LenB; k++) begin
      checks++;
      if (ram_b[k] !== pt_b[k]) begin
        errors++;
        $display("FAIL kat_ram[%0d]: got %h want %h", k, ram_b[k], pt_b[k]);
      end
    end
    bad = 0;
    for (int w = 0; w < m_wr.size() && w < wr_b.size(); w++) if (wr_b[w] !== m_wr[w]) bad++;
    checks++;
    if (wr_b.size() != m_wr.size() || bad != 0) begin
      errors++;
      $display("FAIL kat_s_writes: got %0d writes (%0d differ) want %0d", wr_b.size(), bad,
               m_wr.size());
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_b[x] !== m_s[x]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL kat_final_s: got %0d differing entries want 0", bad);
    end
    start_b = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int cyc;
    preset_a();
    @(posedge clk);
    #1;
    start_a = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    start_a = 1'b0;  // low during cycle 15, second byte in flight
    @(posedge clk);
    #1;
    checks++;
    if ({s_wren_a, ram_wren_a, done_a} !== 3'b000 || u_a.state_q !== StIdle) begin
      errors++;
      $display("FAIL abort_idle: got wren/done %b state %h want 000 %h",
               {s_wren_a, ram_wren_a, done_a}, u_a.state_q, StIdle);
    end
    checks++;
    if (wr_a.size() != 2 || ram_a[0] !== 8'hA2 || ram_a[1] !== 8'h00) begin
      errors++;
      $display("FAIL abort_partial: got %0d S writes ram %h %h want 2 a2 00", wr_a.size(),
               ram_a[0], ram_a[1]);
    end
    // Byte 0 swapped S[1] with itself, so S is still the identity for the rerun.
    wr_a.delete();
    ram_a[0] = 8'h00;
    start_a  = 1'b1;
    run_to_done(0, 100, cyc);
    checks++;
    if (cyc != 26) begin
      errors++;
      $display("FAIL abort_restart_cycle: got %0d want 26", cyc);
    end
    checks++;
    if (ram_a[0] !== 8'hA2 || ram_a[1] !== 8'h50) begin
      errors++;
      $display("FAIL abort_restart_ram: got %h %h want a2 50", ram_a[0], ram_a[1]);
    end
    checks++;
    if (wr_a.size() == 0 || wr_a[0] !== 16'h0101) begin
      errors++;
      $display("FAIL abort_restart_first_write: got %0d writes, want first 0101", wr_a.size());
    end
    start_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int cyc;
    preset_a();
    @(posedge clk);
    #1;
    start_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (s_wren_a !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_write: got s_wren %b want 1", s_wren_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_wren_a, done_a} !== 2'b00 || u_a.state_q !== StIdle) begin
      errors++;
      $display("FAIL areset_write_drop: got s_wren/done %b state %h want 00 %h",
               {s_wren_a, done_a}, u_a.state_q, StIdle);
    end
    start_a = 1'b0;
    rst_n   = 1'b1;
    preset_a();
    @(posedge clk);
    #1;
    start_a = 1'b1;
    run_to_done(0, 100, cyc);
    checks++;
    if (cyc != 26) begin
      errors++;
      $display("FAIL areset_rerun_cycle: got %0d want 26", cyc);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL areset_done_drop: got %b want 0", done_a);
    end
    start_a = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int cyc;
    int bad;
    for (int x = 0; x < 256; x++) begin
      s_c[x] = x[7:0];
      m_s[x] = x[7:0];
    end
    prga_model(LenC);
    for (int k = 0; k < LenC; k++) begin
      pt_c[k]  = 8'($urandom());
      rom_c[k] = pt_c[k] ^ m_ks[k];
      ram_c[k] = 8'h00;
    end
    wr_c.delete();
    @(posedge clk);
    #1;
    start_c = 1'b1;
    run_to_done(2, 5000, cyc);
    checks++;
    if (cyc != 3602) begin
      errors++;
      $display("FAIL wrap_done_cycle: got %0d want 3602", cyc);
    end
    bad = 0;
    for (int k = 0; k < LenC; k++) if (ram_c[k] !== pt_c[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_ram: got %0d wrong bytes want 0", bad);
    end
    bad = 0;
    for (int w = 0; w < m_wr.size() && w < wr_c.size(); w++) if (wr_c[w] !== m_wr[w]) bad++;
    checks++;
    if (wr_c.size() != m_wr.size() || bad != 0) begin
      errors++;
      $display("FAIL wrap_s_writes: got %0d writes (%0d differ) want %0d", wr_c.size(), bad,
               m_wr.size());
    end
    // Bytes 255 and 256 run with i = 0 then i = 1; their first write targets S[i].
    checks++;
    if (wr_c.size() < 514 || wr_c[510][15:8] !== 8'h00 || wr_c[512][15:8] !== 8'h01) begin
      errors++;
      $display("FAIL wrap_i_sequence: got %0d writes, want i=00 at byte 255 and i=01 at 256",
               wr_c.size());
    end
    start_c = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int x = 0; x < 256; x++) begin
      s_a[x] = 8'h00;
      s_b[x] = 8'h00;
      s_c[x] = 8'h00;
    end
    test_reset();
    test_identity();
    test_i_eq_j();
    test_known_answer();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
